muldiv_alu: RTL and testbench
=============================

MULDIV_ALU -- requirements
Module: muldiv_alu

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter SHW, default 5, shift-amount width, equal to log2(XLEN).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  block accepts request this cycle.
REQ-007 SHALL have port fn  input  5  operation code, see REQ-012.
REQ-008 SHALL have port oper1  input  XLEN  first operand (rs1 / dividend / multiplicand).
REQ-009 SHALL have port oper2  input  XLEN  second operand (rs2 / divisor / multiplier / shamt in [SHW-1:0]).
REQ-010 SHALL have ports out_valid output 1, out_ready input 1, out_result output XLEN: result handshake.
REQ-011 SHALL have ports kill input 1 (abort in-flight op) and busy output 1 (state != IDLE).

Function
REQ-012 fn encoding SHALL be: 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 AND, 5 OR, 6 XOR, 7 SL, 8 SR, 9 SRA, 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU; codes 18-31 SHALL execute as ADD.
REQ-013 FSM SHALL have states IDLE, CALC, DONE; in_ready SHALL equal (state == IDLE).
REQ-014 Accept SHALL occur on in_valid && in_ready; fn and operands SHALL be captured into internal registers at accept.
REQ-015 Codes 0-9 and 18-31: IDLE -> DONE; out_valid SHALL assert the cycle after accept (latency 1).
REQ-016 Codes 10-17: IDLE -> CALC; one radix-2 iteration per cycle for exactly XLEN cycles, then -> DONE; out_valid SHALL assert XLEN+1 cycles after accept.
REQ-017 Multiply SHALL compute the 2*XLEN-bit product with operand signedness per RISC-V M; MUL returns low XLEN bits, MULH/MULHSU/MULHU the high XLEN bits.
REQ-018 Divide SHALL use restoring division on magnitudes with sign fix-up; quotient truncates toward zero; remainder takes dividend sign.
REQ-019 Divisor zero SHALL yield quotient all-ones and remainder = oper1, same latency as normal divide.
REQ-020 Signed overflow (oper1 = -2^(XLEN-1), oper2 = -1) SHALL yield DIV = oper1, REM = 0.
REQ-021 SLT/SLTU SHALL return zero-extended 0 or 1; shifts SHALL use only oper2[SHW-1:0]; SRA SHALL sign-fill.
REQ-022 ADD/SUB/MUL SHALL wrap modulo 2^XLEN with no overflow flag.
REQ-023 In DONE, out_result and out_valid SHALL hold stable until out_ready is high; DONE -> IDLE on out_valid && out_ready.
REQ-024 No new request SHALL be accepted in the cycle the result is consumed; the earliest next accept is the following cycle.
REQ-025 kill high in CALC or DONE SHALL force IDLE next cycle with out_valid low; kill in IDLE SHALL have no effect and SHALL NOT block an accept.
REQ-026 kill and out_ready both high in DONE SHALL be treated as kill (result discarded).
REQ-027 busy SHALL be high in CALC and DONE, low in IDLE.

Reset
REQ-028 rst high SHALL immediately force state IDLE, out_valid 0, out_result 0, busy 0, in_ready 1, and clear all iteration counters/datapath registers, including mid-CALC.
REQ-029 After rst deasserts, the first rising edge with in_valid high SHALL accept normally.

Verification
REQ-030 XLEN=32: ADD 0xFFFFFFFF+1 -> 0x00000000 one cycle later; SRA 0x80000000 by oper2=0x24 (shamt 4) -> 0xF8000000.
REQ-031 MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; out_valid exactly 33 cycles after accept.
REQ-032 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; DIV -7/2 -> -3, REM -> -1.
REQ-033 Backpressure: out_ready low 5 cycles after SLT(-1,1) -> out_result holds 1 and out_valid stays high; in_ready low throughout.
REQ-034 kill at CALC cycle 10 of a DIVU -> IDLE next cycle, no out_valid; immediate ADD 3+4 -> 7 correct.
REQ-035 rst pulse asserted mid-MUL between clock edges -> outputs reset without a clock edge; subsequent MUL 6x7 -> 42.

Source files
------------

// File: rtl/muldiv_alu.sv
// ============================================================================
// Module   : muldiv_alu
// Brief    : Handshaked integer ALU with iterative radix-2 multiply/divide.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_alu #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      fn,
    input  logic [XLEN-1:0] oper1,
    input  logic [XLEN-1:0] oper2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    input  logic            kill,
    output logic            busy
);

    localparam int PW = 2 * XLEN;

    localparam logic [4:0] c_ADD    = 5'd0;
    localparam logic [4:0] c_SUB    = 5'd1;
    localparam logic [4:0] c_SLT    = 5'd2;
    localparam logic [4:0] c_SLTU   = 5'd3;
    localparam logic [4:0] c_AND    = 5'd4;
    localparam logic [4:0] c_OR     = 5'd5;
    localparam logic [4:0] c_XOR    = 5'd6;
    localparam logic [4:0] c_SL     = 5'd7;
    localparam logic [4:0] c_SR     = 5'd8;
    localparam logic [4:0] c_SRA    = 5'd9;
    localparam logic [4:0] c_MUL    = 5'd10;
    localparam logic [4:0] c_MULH   = 5'd11;
    localparam logic [4:0] c_MULHSU = 5'd12;
    localparam logic [4:0] c_MULHU  = 5'd13;
    localparam logic [4:0] c_DIV    = 5'd14;
    localparam logic [4:0] c_DIVU   = 5'd15;
    localparam logic [4:0] c_REM    = 5'd16;
    localparam logic [4:0] c_REMU   = 5'd17;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state, w_state_next;
    logic [4:0]        r_fn;
    logic [XLEN-1:0]   r_a, r_b, r_result;
    logic [PW-1:0]     r_p;
    logic [SHW-1:0]    r_cnt;
    logic              r_neg, r_rneg, r_isdiv, r_bzero;

    logic [4:0]        w_fn;
    logic [SHW-1:0]    w_shamt;
    logic              w_accept, w_is_multi, w_is_div, w_last;
    logic              w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [XLEN-1:0]   w_a_mag, w_b_mag, w_alu, w_final, w_q, w_r, w_diff;
    logic [XLEN:0]     w_mul_sum;
    logic              w_ge;
    logic [PW-1:0]     w_mul_next, w_div_next, w_p_next, w_prod_s;

    assign w_fn       = (fn > c_REMU) ? c_ADD : fn;
    assign w_shamt    = oper2[SHW-1:0];
    assign w_accept   = in_valid && (r_state == S_IDLE);
    assign w_is_multi = (w_fn >= c_MUL);
    assign w_is_div   = (w_fn >= c_DIV);
    assign w_last     = (r_cnt == SHW'(XLEN - 1));

    assign w_a_signed = (w_fn == c_MULH) || (w_fn == c_MULHSU) || (w_fn == c_DIV) || (w_fn == c_REM);
    assign w_b_signed = (w_fn == c_MULH) || (w_fn == c_DIV) || (w_fn == c_REM);
    assign w_a_neg    = w_a_signed && oper1[XLEN-1];
    assign w_b_neg    = w_b_signed && oper2[XLEN-1];
    assign w_a_mag    = w_a_neg ? -oper1 : oper1;
    assign w_b_mag    = w_b_neg ? -oper2 : oper2;

    always_comb begin
        w_alu = oper1 + oper2;
        case (w_fn)
            c_SUB:  w_alu = oper1 - oper2;
            c_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(oper1) < $signed(oper2))};
            c_SLTU: w_alu = {{(XLEN-1){1'b0}}, (oper1 < oper2)};
            c_AND:  w_alu = oper1 & oper2;
            c_OR:   w_alu = oper1 | oper2;
            c_XOR:  w_alu = oper1 ^ oper2;
            c_SL:   w_alu = oper1 << w_shamt;
            c_SR:   w_alu = oper1 >> w_shamt;
            c_SRA:  w_alu = $unsigned($signed(oper1) >>> w_shamt);
            default: ;
        endcase
    end

    // r_p holds {high, low}: product accumulator/multiplier for multiply,
    // partial remainder/quotient for divide.
    assign w_mul_sum  = {1'b0, r_p[PW-1:XLEN]} + (r_p[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_p[XLEN-1:1]};
    assign w_ge       = (r_p[PW-1:XLEN-1] >= {1'b0, r_b});
    assign w_diff     = r_p[PW-2:XLEN-1] - r_b;
    assign w_div_next = w_ge ? {w_diff, r_p[XLEN-2:0], 1'b1} : {r_p[PW-2:0], 1'b0};
    assign w_p_next   = r_isdiv ? w_div_next : w_mul_next;

    assign w_prod_s = r_neg ? -w_p_next : w_p_next;
    assign w_q      = w_p_next[XLEN-1:0];
    assign w_r      = w_p_next[PW-1:XLEN];

    always_comb begin
        w_final = w_prod_s[XLEN-1:0];
        case (r_fn)
            c_MULH, c_MULHSU, c_MULHU: w_final = w_prod_s[PW-1:XLEN];
            c_DIV, c_DIVU:             w_final = r_bzero ? {XLEN{1'b1}} : (r_neg ? -w_q : w_q);
            c_REM, c_REMU:             w_final = r_bzero ? r_a : (r_rneg ? -w_r : w_r);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_state_next = w_is_multi ? S_CALC : S_DONE;
            S_CALC: begin
                if (kill)        w_state_next = S_IDLE;
                else if (w_last) w_state_next = S_DONE;
            end
            S_DONE: if (kill || out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fn     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_p      <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_rneg   <= 1'b0;
            r_isdiv  <= 1'b0;
            r_bzero  <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_fn    <= w_fn;
            r_a     <= oper1;
            r_cnt   <= '0;
            r_neg   <= w_a_neg ^ w_b_neg;
            r_rneg  <= w_a_neg;
            r_isdiv <= w_is_div;
            r_bzero <= (oper2 == '0);
            r_p     <= {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
            r_b     <= w_is_div ? w_b_mag : w_a_mag;
            if (!w_is_multi) r_result <= w_alu;
        end else if ((r_state == S_CALC) && !kill) begin
            r_p   <= w_p_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_result <= w_final;
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);
    assign out_result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_alu.sv
// ============================================================================
// Module   : tb_muldiv_alu
// Brief    : Directed self-checking bench for muldiv_alu (XLEN=32).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_alu;

    localparam int XLEN = 32;
    localparam int SHW  = 5;

    logic            clk = 1'b0;
    logic            rst, in_valid, in_ready, out_valid, out_ready, kill, busy;
    logic [4:0]      fn;
    logic [XLEN-1:0] oper1, oper2, out_result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_alu #(.XLEN(XLEN), .SHW(SHW)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fn         (fn),
        .oper1      (oper1),
        .oper2      (oper2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .kill       (kill),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, measure latency to out_valid, check result, consume.
    task automatic run_op(input string tag, input logic [4:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input logic k);
        int lat;
        @(negedge clk);
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        fn = f; oper1 = a; oper2 = b; in_valid = 1'b1; kill = k;
        @(posedge clk);
        #1 in_valid = 1'b0; kill = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check(tag, out_result, exp);
        check({tag, "_busyrdy"}, {30'd0, busy, in_ready}, 32'd2);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; kill = 1'b0;
        fn = '0; oper1 = '0; oper2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid",  32'(out_valid), 32'd0);
        check("rst_ready",  32'(in_ready),  32'd1);
        check("rst_busy",   32'(busy),      32'd0);
        check("rst_result", out_result,     32'd0);
        rst = 1'b0;

        // Single-cycle operations
        run_op("add_wrap", 5'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1'b0);
        run_op("sra",      5'd9,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1, 1'b0);
        run_op("sub",      5'd1,  32'd5,         32'd7,         32'hFFFF_FFFE, 1, 1'b0);
        run_op("sltu",     5'd3,  32'd1,         32'hFFFF_FFFF, 32'd1,         1, 1'b0);
        run_op("slt_neg",  5'd2,  32'd1,         32'hFFFF_FFFF, 32'd0,         1, 1'b0);
        run_op("xor",      5'd6,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1, 1'b0);
        run_op("sl",       5'd7,  32'd1,         32'h0000_003F, 32'h8000_0000, 1, 1'b0);
        run_op("sr",       5'd8,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1, 1'b0);
        run_op("fn20_add", 5'd20, 32'd2,         32'd3,         32'd5,         1, 1'b0);

        // Multiply
        run_op("mulh",   5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b0);
        run_op("mulhu",  5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
        run_op("mulhsu", 5'd12, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33, 1'b0);
        run_op("mul_lo", 5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 1'b0);

        // Divide
        run_op("div_ovf",  5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1'b0);
        run_op("rem_ovf",  5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b0);
        run_op("divu_z",   5'd15, 32'd7,         32'd0,         32'hFFFF_FFFF, 33, 1'b0);
        run_op("remu_z",   5'd17, 32'd7,         32'd0,         32'd7,         33, 1'b0);
        run_op("div_neg",  5'd14, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 1'b0);
        run_op("rem_neg",  5'd16, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 1'b0);
        run_op("div_z",    5'd14, 32'd7,         32'd0,         32'hFFFF_FFFF, 33, 1'b0);
        run_op("rem_z",    5'd16, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 33, 1'b0);
        run_op("divu",     5'd15, 32'd100,       32'd7,         32'd14,        33, 1'b0);
        run_op("remu",     5'd17, 32'd100,       32'd7,         32'd2,         33, 1'b0);

        // Backpressure: result held while out_ready is low
        @(negedge clk);
        fn = 5'd2; oper1 = 32'hFFFF_FFFF; oper2 = 32'd1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_result", out_result, 32'd1);
            check("bp_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("bp_after", {30'd0, out_valid, in_ready}, 32'd1);

        // Kill during CALC cycle 10 of a DIVU
        fn = 5'd15; oper1 = 32'd1000; oper2 = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 kill = 1'b1;
        @(negedge clk);
        check("kill_busy_pre", 32'(busy), 32'd1);
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        check("kill_state", {29'd0, busy, out_valid, in_ready}, 32'd1);
        run_op("add_after_kill", 5'd0, 32'd3, 32'd4, 32'd7, 1, 1'b0);
        run_op("add_idle_kill",  5'd0, 32'd10, 32'd20, 32'd30, 1, 1'b1);

        // Asynchronous reset mid-multiply
        @(negedge clk);
        fn = 5'd10; oper1 = 32'd1234; oper2 = 32'd5678; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_state", {29'd0, busy, out_valid, in_ready}, 32'd1);
        check("arst_result", out_result, 32'd0);
        #1 rst = 1'b0;
        run_op("mul_6x7", 5'd10, 32'd6, 32'd7, 32'd42, 33, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
